// File: rtl/exception_commit_ctrl_pkg.sv
// rtl/exception_commit_ctrl_pkg.sv - shared exception codes and helpers for the commit controller
package exception_commit_ctrl_pkg;

  localparam int EXC_W = 5;

  // Lane codes arrive already prioritised; NONE must stay zero.
  typedef enum logic [EXC_W-1:0] {
    EXC_NONE    = 5'd0,
    EXC_INT     = 5'd1,
    EXC_REFETCH = 5'd2,
    EXC_ERET    = 5'd3,
    EXC_ADEL_IF = 5'd4,
    EXC_TLBR_IF = 5'd5,
    EXC_TLBI_IF = 5'd6,
    EXC_TLBR_L  = 5'd7,
    EXC_TLBI_L  = 5'd8,
    EXC_TLBR_S  = 5'd9,
    EXC_TLBI_S  = 5'd10,
    EXC_MOD     = 5'd11,
    EXC_RI      = 5'd12,
    EXC_CPU     = 5'd13,
    EXC_SYS     = 5'd14,
    EXC_BP      = 5'd15,
    EXC_TR      = 5'd16,
    EXC_OV      = 5'd17,
    EXC_ADEL    = 5'd18,
    EXC_ADES    = 5'd19
  } exc_code_t;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } state_t;

  function automatic logic is_refill(input exc_code_t code);
    return (code == EXC_TLBR_IF) || (code == EXC_TLBR_L) || (code == EXC_TLBR_S);
  endfunction

  // REFETCH and ERET redirect fetch without recording a new exception in CP0.
  function automatic logic writes_cp0(input exc_code_t code);
    return (code != EXC_NONE) && (code != EXC_REFETCH) && (code != EXC_ERET);
  endfunction

endpackage

// File: rtl/exception_commit_ctrl_int_sync.sv
// rtl/exception_commit_ctrl_int_sync.sv - two-flop synchroniser for asynchronous interrupt lines
module exception_commit_ctrl_int_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exception_commit_ctrl.sv
// rtl/exception_commit_ctrl.sv - multi-lane exception arbitration with registered redirect and CP0 commit
module exception_commit_ctrl
  import exception_commit_ctrl_pkg::*;
#(
  parameter int          LANES      = 2,
  parameter int          HW_INT     = 6,
  parameter logic [31:0] BEV_BASE   = 32'hBFC00200,
  parameter logic [31:0] GEN_OFF    = 32'h180,
  parameter logic [31:0] REFILL_OFF = 32'h000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [LANES-1:0]       mem_valid,
  input  logic [LANES*EXC_W-1:0] mem_exc,
  input  logic [LANES*32-1:0]    mem_pc,
  input  logic [HW_INT-1:0]      hw_int,
  input  logic [1:0]             sw_ip,
  input  logic [HW_INT+1:0]      status_im,
  input  logic                   status_exl,
  input  logic                   status_ie,
  input  logic                   status_bev,
  input  logic [31:0]            cp0_ebase,
  input  logic [31:0]            cp0_epc,
  input  logic                   redirect_ready,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic [LANES-1:0]       flush,
  output logic                   stall,
  output logic                   cp0_exc_we,
  output logic                   cp0_eret,
  output logic [EXC_W-1:0]       exc_code,
  output logic [31:0]            exc_pc,
  output logic [HW_INT-1:0]      int_pending
);

  state_t            state;
  exc_code_t         lane_code [LANES];
  logic [31:0]       lane_pc   [LANES];
  logic              int_cond;
  logic              int_take;
  logic              win_found;
  exc_code_t         win_code;
  logic [31:0]       win_pc;
  logic [LANES-1:0]  win_kill;
  logic [31:0]       vec_base;
  logic [31:0]       vec_off;
  logic [31:0]       win_target;

  exception_commit_ctrl_int_sync #(
    .WIDTH (HW_INT)
  ) u_int_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (hw_int),
    .q      (int_pending)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_code[g] = exc_code_t'(mem_exc[g*EXC_W +: EXC_W]);
    assign lane_pc[g]   = mem_pc[g*32 +: 32];
  end

  assign int_cond = (|({int_pending, sw_ip} & status_im)) && status_ie && !status_exl;
  assign int_take = mem_valid[0] && int_cond;

  // Scan youngest to oldest so the oldest excepting lane is the last write.
  always_comb begin
    win_found = 1'b0;
    win_code  = EXC_NONE;
    win_pc    = '0;
    win_kill  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mem_valid[i] && (lane_code[i] != EXC_NONE)) begin
        win_found = 1'b1;
        win_code  = lane_code[i];
        win_pc    = lane_pc[i];
        for (int j = 0; j < LANES; j++) begin
          win_kill[j] = (j >= i);
        end
      end
    end
    if (int_take) begin
      win_found = 1'b1;
      win_code  = EXC_INT;
      win_pc    = lane_pc[0];
      win_kill  = '1;
    end
  end

  always_comb begin
    vec_base = status_bev ? BEV_BASE : cp0_ebase;
    vec_off  = (is_refill(win_code) && !status_exl) ? REFILL_OFF : GEN_OFF;
    case (win_code)
      EXC_REFETCH: win_target = win_pc;
      EXC_ERET:    win_target = cp0_epc;
      default:     win_target = vec_base + vec_off;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= '0;
      stall          <= 1'b0;
      cp0_exc_we     <= 1'b0;
      cp0_eret       <= 1'b0;
      exc_code       <= '0;
      exc_pc         <= '0;
    end else begin
      cp0_exc_we <= 1'b0;
      cp0_eret   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= win_target;
            flush          <= win_kill;
            stall          <= 1'b1;
            cp0_exc_we     <= writes_cp0(win_code);
            cp0_eret       <= (win_code == EXC_ERET);
            exc_code       <= win_code;
            exc_pc         <= win_pc;
          end
        end
        ST_REDIRECT: begin
          // Everything stays frozen until fetch takes the redirect.
          if (redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= '0;
            stall          <= 1'b0;
            exc_code       <= '0;
            exc_pc         <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
